instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage of the RV32I core: owns the fetch PC, issues word reads to instruction memory, and buffers returned words in a small FIFO. It presents `instruction_code` plus its PC to the decode stage, where the immediate extender and control decoder consume it. It handles decode back-pressure, and branch/jump redirects with in-flight response squashing.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries; power of two, ≥2.
- `clk` input, 1: single clock, rising edge.
- `reset` input, 1: asynchronous, active-high.
- `imem_req` output, 1: read request valid.
- `imem_addr` output, 32: word address of the request; bits [1:0] are always 0.
- `imem_ready` input, 1: a request is accepted when `imem_req && imem_ready`.
- `imem_rvalid` input, 1: response valid.
  - Exactly one response per accepted request, returned in order.
  - A response arrives at least 1 cycle after its acceptance.
- `imem_rdata` input, 32: response word.
- `redirect_valid` input, 1: taken branch/jump from execute.
- `redirect_pc` input, 32: redirect target.
- `if_valid` output, 1: `instruction_code`/`if_pc` hold a valid instruction.
- `if_ready` input, 1: decode accepts the instruction.
- `instruction_code` output, 32: instruction word to decode.
- `if_pc` output, 32: address of `instruction_code`.
- `if_pc_plus4` output, 32: `if_pc + 4`, mod 2^32.

## Operation
- **Registers**
  - `pc_q`: next request address.
  - `resp_pc_q`: address of the next kept response.
  - `inflight`: accepted requests with no response yet.
  - `discard`: responses still to be dropped.
  - FIFO of {instr, pc}.
- **Credits.** `credits = FIFO_DEPTH - count - inflight`.
  - `imem_req = !reset && !redirect_valid && credits > 0` (plus `!halt` when `FETCH_MISALIGN_CHECK_EN` is defined).
  - `imem_addr = pc_q`.
  - On acceptance: `pc_q += 4` (wraps mod 2^32) and `inflight++`.
  - The FIFO can never overflow; an overflow is a design error.
- **Responses.** On `imem_rvalid`, `inflight--`.
  - If `discard > 0`: drop the word, `discard--`.
  - Otherwise: push {`imem_rdata`, `resp_pc_q`}, then `resp_pc_q += 4`.
- **Output and pop.**
  - `if_valid = (count != 0) && !redirect_valid`.
  - Pop on `if_valid && if_ready`.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - When `if_valid` is low: `instruction_code = 32'h0000_0013` (NOP) and `if_pc = 0`.
- **Redirect (cycle N).**
  - FIFO flushed; `pc_q` and `resp_pc_q` load `redirect_pc`.
  - `discard` loads `inflight + accepted_this_cycle - (imem_rvalid ? 1 : 0)` plus the current `discard` residue, clamped consistently. Every word in flight at N is squashed.
  - No request is issued in cycle N.
- **Simultaneous events.**
  - Redirect beats pop and push.
  - A response arriving in cycle N is dropped.
  - Back-to-back redirects: the last one wins.

## Timing
- **Reset values.** `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `instruction_code`=NOP, `if_pc`=0, `if_pc_plus4`=4.
- **Reset internal state.** `inflight`=`discard`=`count`=0.
- **First request.** `imem_req` rises in the first cycle after `reset` deasserts.
- **Latency.** A response in cycle R gives `if_valid` in cycle R+1. There is no bypass.
- **Redirect to first valid.** With memory latency L ≥ 1 after acceptance in cycle N+1, the first valid instruction appears in cycle N+2+L.
- **Throughput.** With `FIFO_DEPTH`=2, L=1, `if_ready`=1 and `imem_ready`=1, fetch sustains 1 instruction/cycle.
- **Reset mid-operation.** All state clears asynchronously. Responses for pre-reset requests must not be delivered; the memory side is reset together with this block.

## Configuration
- Macro: `FETCH_MISALIGN_CHECK_EN`.
- **Defined.**
  - A redirect with `redirect_pc[1:0] != 0` sets a sticky `halt` and drives a 1-bit output `fetch_misaligned`=1.
  - While halted: no requests; in-flight responses are discarded.
  - The next aligned redirect clears `halt` and `fetch_misaligned`.
  - Reset value of `fetch_misaligned`: 0.
- **Undefined.**
  - The `fetch_misaligned` port is absent.
  - `redirect_pc[1:0]` is ignored (forced to 0).

## Structure
- **Shared package `fetch_pkg`:**
  - `INSTR_NOP` constant, `32'h0000_0013`.
  - `fetch_entry_t` typedef, packed struct {`logic [31:0] instr; logic [31:0] pc;`}.
  - `PC_STEP` constant, 4.
- **Sub-module `fetch_fifo`:**
  - Parameterised by depth.
  - Ports: push/pop/flush, and `fetch_entry_t` in/out.
  - Exposes `count`.
  - Pointers wrap modulo depth.
- `instr_fetch` keeps the PC, credit, inflight and discard logic.

## Test plan
- **Reset/streaming.** Release reset with `RESET_PC`=`0x100`, 1-cycle memory, `if_ready`=1.
  - Instructions with PCs `0x100`, `0x104`, `0x108`… arrive one per cycle, starting 2 cycles after the first request.
- **Back-pressure.** Hold `if_ready`=0 for 5 cycles.
  - `imem_req` drops once `count + inflight` = 2.
  - No word is lost or duplicated; order resumes at the correct PC.
- **Redirect with inflight.** With 2 outstanding requests at `0x200`/`0x204`, redirect to `0x400`.
  - Both stale responses are dropped.
  - The next `if_valid` shows `if_pc`=`0x400`.
- **Redirect + response + pop.** All three in the same cycle.
  - FIFO is empty next cycle; the response is dropped.
  - `if_valid` was low during the redirect cycle.
- **PC wrap.** `redirect_pc`=`0xFFFF_FFFC`.
  - Fetched PCs are `0xFFFF_FFFC` then `0x0000_0000`.
  - `if_pc_plus4` wraps to 0.
- **`FETCH_MISALIGN_CHECK_EN`.**
  - Redirect to `0x302` sets `fetch_misaligned` and stops requests.
  - A later redirect to `0x300` clears it and resumes fetch at `0x300`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   INSTR_NOP     : word presented to decode when no instruction is valid
//   PC_STEP       : byte increment between sequential instruction words
//   fetch_entry_t : one buffered instruction word plus its address
package fetch_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between instruction memory and decode.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   push_i      : write din_i at the tail
//   pop_i       : drop the head entry
//   flush_i     : empty the buffer (wins over push/pop)
//   din_i       : entry to write
//   dout_o      : head entry (only meaningful when count_o != 0)
//   count_o     : number of stored entries
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               din_i,
    output fetch_entry_t               dout_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; entries are only read once counted.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch stage: owns the fetch PC, issues word reads to
// instruction memory under a credit scheme, buffers returned words and hands
// them to decode. Redirects flush the buffer and squash in-flight responses.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   imem_req/imem_addr    : read request and word address
//   imem_ready            : memory accepts the request this cycle
//   imem_rvalid/imem_rdata: in-order read response
//   redirect_valid/pc     : taken branch/jump from execute
//   if_valid/if_ready     : handshake to decode
//   instruction_code      : instruction word (NOP when not valid)
//   if_pc, if_pc_plus4    : address of instruction_code and that plus 4
//   fetch_misaligned      : sticky misaligned-redirect flag (only when
//                           FETCH_MISALIGN_CHECK_EN is defined)
// Build option: FETCH_MISALIGN_CHECK_EN enables misaligned-redirect halting;
// without it redirect_pc[1:0] is ignored.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] instruction_code,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head, fifo_in;
    logic [SW-1:0] used;
    logic          room, accept, push, pop, halted;
    logic [31:0]   target;

    assign target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    logic halt_q, halt_d;

    assign halt_d = redirect_valid ? (redirect_pc[1:0] != 2'b00) : halt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) halt_q <= 1'b0;
        else       halt_q <= halt_d;
    end

    assign halted           = halt_q;
    assign fetch_misaligned = halt_q;
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign halted              = 1'b0;
`endif

    // A pop this cycle frees an entry before any new request can return
    // (responses are at least one cycle late), so it counts as a credit.
    // Without it a depth-2 buffer with 1-cycle memory could not stream.
    assign used     = SW'(fifo_count) + SW'(inflight_q);
    assign room     = used < (SW'(FIFO_DEPTH) + SW'(pop));
    assign imem_req = !reset && !redirect_valid && !halted && room;
    assign imem_addr = pc_q;
    assign accept   = imem_req && imem_ready;

    assign if_valid = (fifo_count != '0) && !redirect_valid;
    assign pop      = if_valid && if_ready;
    assign push     = imem_rvalid && (discard_q == '0) && !redirect_valid;

    assign fifo_in.instr = imem_rdata;
    assign fifo_in.pc    = resp_pc_q;

    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q + CW'(accept) - CW'(imem_rvalid);
        discard_d  = discard_q;
        if (redirect_valid) begin
            pc_d      = target;
            resp_pc_d = target;
            // No request issues on a redirect, so everything still
            // outstanding after this cycle's response is stale.
            discard_d = inflight_q - CW'(imem_rvalid);
        end else begin
            if (accept) pc_d = pc_q + PC_STEP;
            if (push)   resp_pc_d = resp_pc_q + PC_STEP;
            if (imem_rvalid && discard_q != '0) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .din_i   (fifo_in),
        .dout_o  (fifo_head),
        .count_o (fifo_count)
    );

    always_comb begin
        instruction_code = INSTR_NOP;
        if_pc            = 32'h0000_0000;
        if (if_valid) begin
            instruction_code = fifo_head.instr;
            if_pc            = fifo_head.pc;
        end
    end

    assign if_pc_plus4 = if_pc + PC_STEP;

endmodule
